// File: rtl/axis_read_seq.sv
// axis_read_seq: descriptor sequencer for a stream reader.
// Queues {addr,len} descriptors. For each one it writes the cfg words
// (ID select, start address, length), then counts output-stream handshakes
// until len words have been delivered, and pulses done.
// Optional feature macro: AXIS_READ_SEQ_STATUS_EN (live beat_cnt and sticky err).
module axis_read_seq #(
  parameter int                    CFG_AWIDTH  = 5,
  parameter int                    CFG_DWIDTH  = 32,
  parameter int                    DESC_AWIDTH = 2,
  parameter logic [CFG_DWIDTH-1:0] CFG_ID      = CFG_DWIDTH'(1),
  parameter logic [CFG_AWIDTH-1:0] CFG_ADDR    = CFG_AWIDTH'(23),
  parameter logic [CFG_AWIDTH-1:0] CFG_DATA    = CFG_AWIDTH'(24)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] desc_addr,
  input  logic [CFG_DWIDTH-1:0] desc_len,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  mon_valid,
  input  logic                  mon_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CFG_DWIDTH-1:0] beat_cnt,
  output logic                  err
);

  localparam int DEPTH = 1 << DESC_AWIDTH;
  localparam logic [DESC_AWIDTH:0]   FULL_CNT = (DESC_AWIDTH+1)'(DEPTH);
  localparam logic [DESC_AWIDTH:0]   CNT_ONE  = (DESC_AWIDTH+1)'(1);
  localparam logic [DESC_AWIDTH-1:0] PTR_ONE  = DESC_AWIDTH'(1);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_SEL  = 6'b000010,
    S_ADDR = 6'b000100,
    S_LEN  = 6'b001000,
    S_RUN  = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t                  state_q, state_d;
  logic [CFG_DWIDTH-1:0]   addr_mem_q [DEPTH];
  logic [CFG_DWIDTH-1:0]   addr_mem_d [DEPTH];
  logic [CFG_DWIDTH-1:0]   len_mem_q  [DEPTH];
  logic [CFG_DWIDTH-1:0]   len_mem_d  [DEPTH];
  logic [DESC_AWIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DESC_AWIDTH:0]    count_q, count_d;
  logic                    desc_ready_q, desc_ready_d;
  logic [CFG_DWIDTH-1:0]   work_addr_q, work_addr_d, work_len_q, work_len_d;
  logic [CFG_DWIDTH-1:0]   cnt_q, cnt_d, cnt_inc_s;
  logic                    cfg_valid_q, cfg_valid_d;
  logic [CFG_AWIDTH-1:0]   cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0]   cfg_data_q, cfg_data_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    push_s, pop_s, beat_s;

  // desc_ready is a flop, so a same-cycle pop never frees a slot for a push
  assign push_s    = desc_valid & desc_ready_q;
  assign pop_s     = (state_q == S_IDLE) && (count_q != '0);
  assign beat_s    = mon_valid & mon_ready;
  assign cnt_inc_s = cnt_q + CFG_DWIDTH'(1);

  // Descriptor FIFO: storage, wrapping pointers and occupancy
  always_comb begin
    addr_mem_d = addr_mem_q;
    len_mem_d  = len_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      addr_mem_d[wr_ptr_q] = desc_addr;
      len_mem_d[wr_ptr_q]  = desc_len;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    desc_ready_d = (count_d != FULL_CNT);
  end

  // Sequencer next state, working descriptor and beat counter
  always_comb begin
    state_d     = state_q;
    work_addr_d = work_addr_q;
    work_len_d  = work_len_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          work_addr_d = addr_mem_q[rd_ptr_q];
          work_len_d  = len_mem_q[rd_ptr_q];
          if (len_mem_q[rd_ptr_q] == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL:  state_d = S_ADDR;
      S_ADDR: state_d = S_LEN;
      S_LEN: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (beat_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == work_len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state; cfg bus is zero when idle
  always_comb begin
    cfg_valid_d = 1'b0;
    cfg_addr_d  = '0;
    cfg_data_d  = '0;
    case (state_d)
      S_SEL: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_ADDR;
        cfg_data_d  = CFG_ID;
      end
      S_ADDR: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_DATA;
        cfg_data_d  = work_addr_d;
      end
      S_LEN: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_DATA;
        cfg_data_d  = work_len_d;
      end
      default: begin
        cfg_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, queue and output registers; reset discards all descriptors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_mem_q   <= '{default: '0};
      len_mem_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      desc_ready_q <= 1'b1;
      work_addr_q  <= '0;
      work_len_q   <= '0;
      cnt_q        <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_mem_q   <= addr_mem_d;
      len_mem_q    <= len_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      desc_ready_q <= desc_ready_d;
      work_addr_q  <= work_addr_d;
      work_len_q   <= work_len_d;
      cnt_q        <= cnt_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_data_q   <= cfg_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign desc_ready = desc_ready_q;
  assign cfg_valid  = cfg_valid_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef AXIS_READ_SEQ_STATUS_EN
  logic err_q, err_d;

  // Sticky error: any stream handshake seen while not in RUN
  always_comb begin
    err_d = err_q | (beat_s & (state_q != S_RUN));
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign beat_cnt = cnt_q;
  assign err      = err_q;
`else
  assign beat_cnt = '0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_axis_read_seq.sv
// Self-checking bench for axis_read_seq: table-driven descriptors plus
// hand-written corner sequences; cfg words are checked via a scoreboard.
module tb_axis_read_seq;

`ifdef AXIS_READ_SEQ_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] desc_addr, desc_len;
  logic        desc_valid, desc_ready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid, mon_valid, mon_ready, busy, done, err;
  logic [31:0] beat_cnt;

  always #5 clk = ~clk;

  axis_read_seq dut (
    .clk(clk), .rst(rst),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .mon_valid(mon_valid), .mon_ready(mon_ready),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } cfg_word_t;
  cfg_word_t sb[$];
  cfg_word_t mon_w;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    bit          tog;
    logic [31:0] exp_beat;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bc(input logic [31:0] l);
    return STATUS ? l : 32'd0;
  endfunction

  // Scoreboard consumer: every cfg word must match the next expected one
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (cfg_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cfg_unexpected: got addr %0d data 0x%0h expected no word", cfg_addr, cfg_data);
        end else begin
          mon_w = sb.pop_front();
          check("cfg_addr", 32'(cfg_addr), 32'(mon_w.a));
          check("cfg_data", cfg_data, mon_w.d);
        end
      end else begin
        check("cfg_idle_zero", 32'(cfg_addr) | cfg_data, 32'd0);
      end
    end
  end

  task automatic sb_push(input logic [31:0] a, input logic [31:0] l);
    sb.push_back('{5'd23, 32'd1});
    sb.push_back('{5'd24, a});
    sb.push_back('{5'd24, l});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [31:0] a, input logic [31:0] l);
    int t = 0;
    while (!desc_ready && t < 50) begin step(); t++; end
    check("push_ready", 32'(desc_ready), 32'd1);
    desc_addr  = a;
    desc_len   = l;
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    if (l != 32'd0) sb_push(a, l);
  endtask

  task automatic wait_run(output int lat);
    int t = 0;
    while (!cfg_valid && t < 50) begin step(); t++; end
    check("wait_cfg_start", 32'(cfg_valid), 32'd1);
    t = 0;
    while (cfg_valid && t < 10) begin step(); t++; end
    check("wait_run", 32'(cfg_valid), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    lat = t;
  endtask

  task automatic beats(input logic [31:0] l, input bit tog, input logic [31:0] exp_beat);
    int given = 0;
    int cyc = 0;
    while (given < int'(l) && cyc < 400) begin
      mon_valid = 1'b1;
      mon_ready = tog ? cyc[0] : 1'b1;
      step();
      if (mon_ready) given++;
      cyc++;
      if (given < int'(l)) check("done_early", 32'(done), 32'd0);
    end
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("beat_cnt", beat_cnt, exp_beat);
    exp_done++;
    step();
    check("done_once", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic do_vec(input logic [31:0] a, input logic [31:0] l, input bit tog,
                        input logic [31:0] exp_beat);
    int lat;
    push_desc(a, l);
    step();
    check("sel_latency", 32'(cfg_valid), 32'd1);
    check("sel_addr", 32'(cfg_addr), 32'd23);
    wait_run(lat);
    check("cfg_three_words", 32'(lat), 32'd3);
    beats(l, tog, exp_beat);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    logic [31:0] q_len [5];

    vecs[0] = '{32'h0000_1000, 32'd8, 1'b0, bc(32'd8)};
    vecs[1] = '{32'hABCD_0000, 32'd5, 1'b1, bc(32'd5)};
    vecs[2] = '{32'h0000_0000, 32'd1, 1'b0, bc(32'd1)};
    vecs[3] = '{32'hFFFF_FFFC, 32'd3, 1'b1, bc(32'd3)};

    rst = 1'b0; desc_addr = 32'd0; desc_len = 32'd0; desc_valid = 1'b0;
    mon_valid = 1'b0; mon_ready = 1'b0;
    #23;
    check("rst_desc_ready", 32'(desc_ready), 32'd1);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("rst_cfg_data", cfg_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_beat_cnt", beat_cnt, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b1;
    step(); step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cfg_valid", 32'(cfg_valid), 32'd0);

    // Table of single descriptors with exact latency checks
    for (int i = 0; i < 4; i++) begin
      do_vec(vecs[i].addr, vecs[i].len, vecs[i].tog, vecs[i].exp_beat);
      check("vec_err", 32'(err), 32'd0);
    end

    // Fill the queue while the FSM is stalled in RUN
    q_len = '{32'd3, 32'd1, 32'd2, 32'd4, 32'd1};
    push_desc(32'h7000, 32'd2);
    wait_run(lat);
    for (int i = 0; i < 4; i++) push_desc(32'hA000 + 32'(i) * 32'h1000, q_len[i]);
    check("full_ready", 32'(desc_ready), 32'd0);
    desc_addr = 32'hE000; desc_len = q_len[4]; desc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_held", 32'(desc_ready), 32'd0);
    end
    beats(32'd2, 1'b0, bc(32'd2));
    check("no_same_cycle_free", 32'(desc_ready), 32'd0);
    t = 0;
    while (!desc_ready && t < 10) begin step(); t++; end
    check("ready_after_pop", 32'(desc_ready), 32'd1);
    step();
    desc_valid = 1'b0;
    sb_push(32'hE000, q_len[4]);
    for (int i = 0; i < 5; i++) begin
      wait_run(lat);
      beats(q_len[i], 1'b0, bc(q_len[i]));
    end

    // Zero-length descriptor between two len=4 descriptors
    push_desc(32'h100, 32'd4);
    push_desc(32'h200, 32'd0);
    push_desc(32'h300, 32'd4);
    wait_run(lat);
    beats(32'd4, 1'b0, bc(32'd4));
    step();
    check("zero_done", 32'(done), 32'd1);
    check("zero_no_cfg", 32'(cfg_valid), 32'd0);
    exp_done++;
    step();
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_idle_cfg", 32'(cfg_valid), 32'd0);
    step();
    check("after_zero_sel", 32'(cfg_valid), 32'd1);
    wait_run(lat);
    beats(32'd4, 1'b1, bc(32'd4));

    // Handshake outside RUN sets the sticky error
    mon_valid = 1'b1; mon_ready = 1'b0;
    step();
    check("err_no_handshake", 32'(err), 32'd0);
    mon_ready = 1'b1;
    step();
    mon_valid = 1'b0; mon_ready = 1'b0;
    check("err_set", 32'(err), 32'(STATUS));
    step();
    check("err_sticky", 32'(err), 32'(STATUS));
    do_vec(32'h3000, 32'd2, 1'b0, bc(32'd2));
    check("err_after_desc", 32'(err), 32'(STATUS));

    // Reset in the middle of the ADDR word with two descriptors queued
    push_desc(32'h4000, 32'd6);
    push_desc(32'h4100, 32'd2);
    push_desc(32'h4200, 32'd2);
    check("pre_rst_addr_word", cfg_data, 32'h4000);
    rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("mid_rst_cfg_data", cfg_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(desc_ready), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_idle", 32'(busy), 32'd0);
    end
    check("post_rst_no_done", 32'(done_cnt), 32'(exp_done));
    do_vec(32'h5000, 32'd2, 1'b0, bc(32'd2));

    step(); step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
